// File: rtl/issue_queue.sv
// Compacting out-of-order issue queue: buffers dispatched ops until both source
// tags are ready and the target FU accepts, then issues the oldest eligible op.
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int NR_WB     = 2,
  parameter int TAG_W     = 6,
  parameter int NR_FU     = 4,
  parameter int PAYLOAD_W = 64,
  localparam int FU_W     = $clog2(NR_FU),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAG_W-1:0]       in_prs1,
  input  logic                   in_prs1_rdy,
  input  logic [TAG_W-1:0]       in_prs2,
  input  logic                   in_prs2_rdy,
  input  logic [FU_W-1:0]        in_fu,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  input  logic [NR_WB-1:0]       wb_valid,
  input  logic [NR_WB*TAG_W-1:0] wb_tag,
  input  logic [NR_FU-1:0]       fu_ready,
  output logic                   out_valid,
  output logic [FU_W-1:0]        out_fu,
  output logic [TAG_W-1:0]       out_prs1,
  output logic [TAG_W-1:0]       out_prs2,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [CNT_W-1:0]       count
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [TAG_W-1:0]     prs1_reg [DEPTH];
  logic [TAG_W-1:0]     prs1_next [DEPTH];
  logic [TAG_W-1:0]     prs2_reg [DEPTH];
  logic [TAG_W-1:0]     prs2_next [DEPTH];
  logic [FU_W-1:0]      fu_reg [DEPTH];
  logic [FU_W-1:0]      fu_next [DEPTH];
  logic [PAYLOAD_W-1:0] payload_reg [DEPTH];
  logic [PAYLOAD_W-1:0] payload_next [DEPTH];
  logic [DEPTH-1:0]     rdy1_reg, rdy1_next, rdy2_reg, rdy2_next;
  logic [CNT_W-1:0]     count_reg, count_next, tail;

  logic [DEPTH-1:0][NR_WB-1:0] match1, match2;
  logic [NR_WB-1:0]            in_match1, in_match2;
  logic [DEPTH-1:0]            wake1, wake2, eligible;
  logic                        in_wake1, in_wake2;
  logic                        found, iss, enq;
  logic [IDX_W-1:0]            sel;

  // Tag comparators: every wakeup port against every resident and incoming source.
  genvar gi, gk;
  generate
    for (gk = 0; gk < NR_WB; gk++) begin : g_in_wb
      assign in_match1[gk] = wb_valid[gk] && (wb_tag[gk*TAG_W +: TAG_W] == in_prs1);
      assign in_match2[gk] = wb_valid[gk] && (wb_tag[gk*TAG_W +: TAG_W] == in_prs2);
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      for (gk = 0; gk < NR_WB; gk++) begin : g_wb
        assign match1[gi][gk] = wb_valid[gk] && (wb_tag[gk*TAG_W +: TAG_W] == prs1_reg[gi]);
        assign match2[gi][gk] = wb_valid[gk] && (wb_tag[gk*TAG_W +: TAG_W] == prs2_reg[gi]);
      end
      assign wake1[gi]    = |match1[gi];
      assign wake2[gi]    = |match2[gi];
      assign eligible[gi] = (CNT_W'(gi) < count_reg) && rdy1_reg[gi] && rdy2_reg[gi]
                            && fu_ready[fu_reg[gi]];
    end
  endgenerate

  assign in_wake1 = |in_match1;
  assign in_wake2 = |in_match2;
  assign in_ready = (count_reg < CNT_W'(DEPTH));
  assign enq      = in_valid && in_ready && !flush;
  assign found    = |eligible;
  assign iss      = found && !flush && rstn;
  assign tail     = count_reg - CNT_W'(iss);
  assign count    = count_reg;

  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) sel = IDX_W'(i);
    end
  end

  always_comb begin
    out_valid   = iss;
    out_fu      = '0;
    out_prs1    = '0;
    out_prs2    = '0;
    out_payload = '0;
    if (iss) begin
      out_fu      = fu_reg[sel];
      out_prs1    = prs1_reg[sel];
      out_prs2    = prs2_reg[sel];
      out_payload = payload_reg[sel];
    end
  end

  // Wakeups follow an entry into its shifted slot; the enqueue lands on the post-compaction tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      prs1_next[i]    = prs1_reg[i];
      prs2_next[i]    = prs2_reg[i];
      fu_next[i]      = fu_reg[i];
      payload_next[i] = payload_reg[i];
      rdy1_next[i]    = rdy1_reg[i] | wake1[i];
      rdy2_next[i]    = rdy2_reg[i] | wake2[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (iss && (i >= int'(sel))) begin
        prs1_next[i]    = prs1_reg[i+1];
        prs2_next[i]    = prs2_reg[i+1];
        fu_next[i]      = fu_reg[i+1];
        payload_next[i] = payload_reg[i+1];
        rdy1_next[i]    = rdy1_reg[i+1] | wake1[i+1];
        rdy2_next[i]    = rdy2_reg[i+1] | wake2[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && (CNT_W'(i) == tail)) begin
        prs1_next[i]    = in_prs1;
        prs2_next[i]    = in_prs2;
        fu_next[i]      = in_fu;
        payload_next[i] = in_payload;
        rdy1_next[i]    = in_prs1_rdy | in_wake1;
        rdy2_next[i]    = in_prs2_rdy | in_wake2;
      end
    end
    count_next = count_reg + CNT_W'(enq) - CNT_W'(iss);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_reg <= '0;
      rdy1_reg  <= '0;
      rdy2_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        prs1_reg[i]    <= '0;
        prs2_reg[i]    <= '0;
        fu_reg[i]      <= '0;
        payload_reg[i] <= '0;
      end
    end else if (flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
      rdy1_reg  <= rdy1_next;
      rdy2_reg  <= rdy2_next;
      for (int i = 0; i < DEPTH; i++) begin
        prs1_reg[i]    <= prs1_next[i];
        prs2_reg[i]    <= prs2_next[i];
        fu_reg[i]      <= fu_next[i];
        payload_reg[i] <= payload_next[i];
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: ordering, wakeup, FU selection, full, flush and reset.
module tb_issue_queue;
  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready;
  logic [5:0]  in_prs1, in_prs2;
  logic        in_prs1_rdy, in_prs2_rdy;
  logic [1:0]  in_fu;
  logic [63:0] in_payload;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [3:0]  fu_ready;
  logic        out_valid;
  logic [1:0]  out_fu;
  logic [5:0]  out_prs1, out_prs2;
  logic [63:0] out_payload;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  issue_queue dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prs1(in_prs1), .in_prs1_rdy(in_prs1_rdy),
    .in_prs2(in_prs2), .in_prs2_rdy(in_prs2_rdy),
    .in_fu(in_fu), .in_payload(in_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .fu_ready(fu_ready),
    .out_valid(out_valid), .out_fu(out_fu),
    .out_prs1(out_prs1), .out_prs2(out_prs2),
    .out_payload(out_payload), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && out_valid)
      $display("issue: fu=%0d prs1=%0d prs2=%0d payload=%h count=%0d",
               out_fu, out_prs1, out_prs2, out_payload, count);
  end

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_valid = 2'b00; wb_tag = '0;
    in_prs1 = '0; in_prs2 = '0; in_prs1_rdy = 1'b0; in_prs2_rdy = 1'b0;
    in_fu = '0; in_payload = '0;
  endtask

  task automatic put(input logic [5:0] p1, input logic r1, input logic [5:0] p2,
                     input logic r2, input logic [1:0] fu, input logic [63:0] pl);
    in_valid = 1'b1; in_prs1 = p1; in_prs1_rdy = r1; in_prs2 = p2; in_prs2_rdy = r2;
    in_fu = fu; in_payload = pl;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); rstn = 1'b0; fu_ready = 4'b1111;
    put(0, 1, 0, 1, 0, 64'hDEAD);
    repeat (2) @(negedge clk);
    idle(); rstn = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (out_payload !== 64'h0) begin errors++; $display("FAIL rst_payload: got %h want 0", out_payload); end
  endtask

  task automatic test_in_order();
    fu_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); put(0, 1, 0, 1, 0, 64'h101 + 64'(i));
    end
    @(negedge clk); idle(); fu_ready = 4'b0001; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (count !== 4'(3 - i)) begin errors++; $display("FAIL ord_count%0d: got %0d want %0d", i, count, 3 - i); end
      checks++; if (out_valid !== 1'b1 || out_payload !== 64'h101 + 64'(i))
        begin errors++; $display("FAIL ord_issue%0d: got v=%0b %h want v=1 %h", i, out_valid, out_payload, 64'h101 + 64'(i)); end
    end
    @(negedge clk); #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL ord_empty: got count=%0d v=%0b want 0 0", count, out_valid); end
  endtask

  task automatic test_wakeup();
    fu_ready = 4'b0010;
    @(negedge clk); idle(); put(5, 0, 0, 1, 1, 64'hA0); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wk_c0: got v=%0b want 0", out_valid); end
    @(negedge clk); idle(); put(0, 1, 0, 1, 1, 64'hB0); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wk_a_blocked: got v=%0b want 0", out_valid); end
    @(negedge clk); idle(); wb_valid = 2'b10; wb_tag = {6'd5, 6'd0}; #1;
    checks++; if (out_valid !== 1'b1 || out_payload !== 64'hB0) begin errors++; $display("FAIL wk_b_first: got v=%0b %h want v=1 b0", out_valid, out_payload); end
    @(negedge clk); idle(); #1;
    checks++; if (out_valid !== 1'b1 || out_payload !== 64'hA0) begin errors++; $display("FAIL wk_a_issue: got v=%0b %h want v=1 a0", out_valid, out_payload); end
    checks++; if (out_prs1 !== 6'd5 || out_fu !== 2'd1) begin errors++; $display("FAIL wk_a_fields: got prs1=%0d fu=%0d want 5 1", out_prs1, out_fu); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL wk_count: got %0d want 1", count); end
    @(negedge clk); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wk_empty: got %0d want 0", count); end
  endtask

  task automatic test_enq_wakeup();
    fu_ready = 4'b0001;
    @(negedge clk); idle(); put(3, 1, 9, 0, 0, 64'hC0); wb_valid = 2'b01; wb_tag = {6'd0, 6'd9}; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ew_same_cycle: got v=%0b want 0", out_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (out_valid !== 1'b1 || out_payload !== 64'hC0 || out_prs2 !== 6'd9)
      begin errors++; $display("FAIL ew_issue: got v=%0b %h prs2=%0d want v=1 c0 9", out_valid, out_payload, out_prs2); end
    @(negedge clk); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL ew_empty: got %0d want 0", count); end
  endtask

  task automatic test_full();
    fu_ready = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle(); put(0, 1, 0, 1, 2'(i), 64'h200 + 64'(i));
    end
    @(negedge clk); idle(); put(0, 1, 0, 1, 0, 64'h2FF); fu_ready = 4'b1111; #1;
    checks++; if (in_ready !== 1'b0 || count !== 4'd8) begin errors++; $display("FAIL full_state: got rdy=%0b count=%0d want 0 8", in_ready, count); end
    checks++; if (out_valid !== 1'b1 || out_payload !== 64'h200) begin errors++; $display("FAIL full_issue: got v=%0b %h want v=1 200", out_valid, out_payload); end
    @(negedge clk); idle(); put(0, 1, 0, 1, 0, 64'h300); #1;
    checks++; if (in_ready !== 1'b1 || count !== 4'd7) begin errors++; $display("FAIL full_after: got rdy=%0b count=%0d want 1 7", in_ready, count); end
    checks++; if (out_payload !== 64'h201) begin errors++; $display("FAIL full_i1: got %h want 201", out_payload); end
    @(negedge clk); idle(); #1;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_enq_iss: got %0d want 7", count); end
    for (int i = 2; i < 8; i++) begin
      if (i > 2) begin @(negedge clk); #1; end
      checks++; if (out_valid !== 1'b1 || out_payload !== 64'h200 + 64'(i))
        begin errors++; $display("FAIL full_drain%0d: got v=%0b %h want v=1 %h", i, out_valid, out_payload, 64'h200 + 64'(i)); end
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_payload !== 64'h300) begin errors++; $display("FAIL full_last: got v=%0b %h want v=1 300", out_valid, out_payload); end
    @(negedge clk); #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got count=%0d v=%0b want 0 0", count, out_valid); end
  endtask

  task automatic test_fu_select();
    fu_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); put(0, 1, 0, 1, 2'(i), 64'h400 + 64'(i));
    end
    @(negedge clk); idle(); fu_ready = 4'b0100; #1;
    checks++; if (out_valid !== 1'b1 || out_fu !== 2'd2 || out_payload !== 64'h402)
      begin errors++; $display("FAIL fu_sel: got v=%0b fu=%0d %h want v=1 fu=2 402", out_valid, out_fu, out_payload); end
    @(negedge clk); fu_ready = 4'b0000; #1;
    checks++; if (out_valid !== 1'b0 || count !== 4'd3) begin errors++; $display("FAIL fu_remain: got v=%0b count=%0d want 0 3", out_valid, count); end
    @(negedge clk); fu_ready = 4'b1111; #1;
    checks++; if (out_payload !== 64'h400) begin errors++; $display("FAIL fu_rest0: got %h want 400", out_payload); end
    @(negedge clk); #1;
    checks++; if (out_payload !== 64'h401) begin errors++; $display("FAIL fu_rest1: got %h want 401", out_payload); end
    @(negedge clk); #1;
    checks++; if (out_payload !== 64'h403 || out_fu !== 2'd3) begin errors++; $display("FAIL fu_rest3: got %h fu=%0d want 403 3", out_payload, out_fu); end
    @(negedge clk); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL fu_empty: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    fu_ready = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle(); put(12, 1, 0, 1, 0, 64'h500 + 64'(i));
    end
    @(negedge clk); idle(); put(12, 0, 0, 1, 0, 64'h5FF); flush = 1'b1;
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd12}; fu_ready = 4'b1111; #1;
    checks++; if (out_valid !== 1'b0 || count !== 4'd5) begin errors++; $display("FAIL fl_cycle: got v=%0b count=%0d want 0 5", out_valid, count); end
    @(negedge clk); idle(); #1;
    checks++; if (count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL fl_after: got count=%0d rdy=%0b v=%0b want 0 1 0", count, in_ready, out_valid); end
    @(negedge clk); #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_enq: got count=%0d v=%0b want 0 0", count, out_valid); end
  endtask

  task automatic test_reset_mid();
    fu_ready = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); put(0, 1, 0, 1, 0, 64'h600 + 64'(i));
    end
    @(negedge clk); idle(); rstn = 1'b0; flush = 1'b1; fu_ready = 4'b1111; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_issue: got v=%0b want 0", out_valid); end
    @(negedge clk); idle(); rstn = 1'b1; #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_after: got count=%0d v=%0b want 0 0", count, out_valid); end
  endtask

  initial begin
    rstn = 1'b0; fu_ready = 4'b0000; idle();
    test_reset();
    test_in_order();
    test_wakeup();
    test_enq_wakeup();
    test_full();
    test_fu_select();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
